// File: rtl/tone_sequencer.sv
// tone_sequencer: arbitrates two note requesters (A = background tune,
// B = game effects, B has priority) onto one buzzer tone generator.
// Each accepted {note, duration} command plays for dur*BEAT_CYCLES cycles,
// followed by GAP_CYCLES of silence so repeated notes articulate.
//
// Handshake: a command transfers on a rising edge where valid & ready are
// both high. Ready is combinational and depends only on the FSM being IDLE,
// abort being low, rst_n being high and (for A only) b_valid being low, so a
// requester may hold valid for as long as it likes; note/dur are sampled only
// on the transfer edge.
module tone_sequencer #(
    parameter int unsigned BEAT_CYCLES = 10344828,
    parameter int unsigned GAP_CYCLES  = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    input  logic [3:0] a_note,
    input  logic [3:0] a_dur,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [3:0] b_note,
    input  logic [3:0] b_dur,
    output logic       b_ready,
    input  logic       abort,
    input  logic       mute,
    output logic [3:0] node,
    output logic       busy,
    output logic       src_b,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NOTE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYCLES - 1);
    localparam logic [31:0] GAP_LAST  = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  note_q;
    logic [3:0]  last_unit_q;   // D-1; a dur of 0 wraps to 15, i.e. 16 beats
    logic [31:0] cyc_q;         // cycles within a beat, or within the gap
    logic [4:0]  unit_q;        // beats completed in the current note
    logic [3:0]  node_q;
    logic        busy_q;
    logic        src_b_q;

    logic        idle;
    logic        a_take;
    logic        b_take;
    logic        beat_end;
    logic        note_end;
    logic        gap_end;
    logic [3:0]  sel_note_d;
    logic [3:0]  sel_dur_d;
    logic [31:0] cyc_d;
    logic [4:0]  unit_d;

    // Handshake, arbitration and end-of-period decode.
    always_comb begin
        idle       = (state_q == S_IDLE);
        b_ready    = rst_n & idle & ~abort;
        a_ready    = rst_n & idle & ~abort & ~b_valid;
        b_take     = b_valid & b_ready;
        a_take     = a_valid & a_ready;
        sel_note_d = b_take ? b_note : a_note;
        sel_dur_d  = b_take ? b_dur : a_dur;
        cyc_d      = cyc_q + 32'd1;
        unit_d     = unit_q + 5'd1;
        beat_end   = (cyc_q == BEAT_LAST);
        note_end   = beat_end && (unit_q == {1'b0, last_unit_q});
        gap_end    = (cyc_q == GAP_LAST);
    end

    // Main FSM with registered node/busy/src_b outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            note_q      <= 4'd0;
            last_unit_q <= 4'd0;
            cyc_q       <= 32'd0;
            unit_q      <= 5'd0;
            node_q      <= 4'd0;
            busy_q      <= 1'b0;
            src_b_q     <= 1'b0;
        end else if (abort) begin
            // src_b is deliberately left alone so it still names the last source.
            state_q <= S_IDLE;
            cyc_q   <= 32'd0;
            unit_q  <= 5'd0;
            node_q  <= 4'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    node_q <= 4'd0;
                    if (a_take || b_take) begin
                        state_q     <= S_NOTE;
                        note_q      <= sel_note_d;
                        last_unit_q <= sel_dur_d - 4'd1;
                        src_b_q     <= b_take;
                        cyc_q       <= 32'd0;
                        unit_q      <= 5'd0;
                        busy_q      <= 1'b1;
                        node_q      <= mute ? 4'd0 : sel_note_d;
                    end
                end
                S_NOTE: begin
                    node_q <= mute ? 4'd0 : note_q;
                    if (note_end) begin
                        cyc_q  <= 32'd0;
                        unit_q <= 5'd0;
                        node_q <= 4'd0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end else if (beat_end) begin
                        cyc_q  <= 32'd0;
                        unit_q <= unit_d;
                    end else begin
                        cyc_q <= cyc_d;
                    end
                end
                S_GAP: begin
                    node_q <= 4'd0;
                    if (gap_end) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cyc_q   <= 32'd0;
                    end else begin
                        cyc_q <= cyc_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    node_q  <= 4'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign node      = node_q;
    assign busy      = busy_q;
    assign src_b     = src_b_q;
    assign dbg_state = state_q;

endmodule
